// File: rtl/rv_div_pkg.sv
// Shared types and defaults for the RV32M divider.
package rv_div_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/rv_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module rv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quot_nxt
);

  logic [XLEN:0] shifted_rem;
  logic [XLEN:0] trial;

  // Shift {rem,quot} left, trial-subtract and keep the difference only if it did not go negative.
  // rem < divisor on entry, so the shifted value fits in XLEN+1 bits.
  always_comb begin
    shifted_rem = {rem, quot[XLEN-1]};
    trial       = shifted_rem - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_nxt  = trial[XLEN-1:0];
      quot_nxt = {quot[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt  = shifted_rem[XLEN-1:0];
      quot_nxt = {quot[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) feeding the register-file write port.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one restoring step per cycle, XLEN cycles
// DONE  | result strobe (valid_o) for one cycle
module rv_div_unit
  import rv_div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ADDRW = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [ADDRW-1:0] rd_addr_i,
  output logic             valid_o,
  output logic [ADDRW-1:0] rd_addr_o,
  output logic [XLEN-1:0]  rd_data_o,
  output logic             rd_wren_o,
  output logic             busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [XLEN-1:0]  quot_q, rem_q, divisor_q;
  div_op_e          op_q;
  logic [ADDRW-1:0] rd_addr_q;
  logic             neg_quot_q, neg_rem_q;
  logic             valid_q;
  logic [ADDRW-1:0] rd_addr_out_q;
  logic [XLEN-1:0]  rd_data_q;

  logic            is_signed, a_neg, b_neg, div_zero, overflow, short_path;
  logic [XLEN-1:0] rs1_mag, rs2_mag, short_quot, short_rem;
  logic [XLEN-1:0] quot_nxt, rem_nxt, quot_fix, rem_fix;
  logic            is_rem_q;

  // Operand decode at accept time: magnitudes, sign flags and the short-path results.
  always_comb begin
    is_signed  = ~op_i[0];
    a_neg      = is_signed & rs1_data_i[XLEN-1];
    b_neg      = is_signed & rs2_data_i[XLEN-1];
    rs1_mag    = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
    rs2_mag    = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
    div_zero   = (rs2_data_i == '0);
    overflow   = is_signed && (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
    short_path = div_zero | overflow;
    short_quot = div_zero ? '1 : INT_MIN;
    short_rem  = div_zero ? rs1_data_i : '0;
  end

  rv_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quot     (quot_q),
    .divisor  (divisor_q),
    .rem_nxt  (rem_nxt),
    .quot_nxt (quot_nxt)
  );

  // Sign fix on the final step's output; unsigned ops never set the neg flags.
  always_comb begin
    quot_fix = neg_quot_q ? (~quot_nxt + 1'b1) : quot_nxt;
    rem_fix  = neg_rem_q  ? (~rem_nxt + 1'b1)  : rem_nxt;
    is_rem_q = (op_q == REM) || (op_q == REMU);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush forces IDLE from anywhere and blocks an accept.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_i) state_d = short_path ? DONE : CALC;
        CALC:    if (cnt_q == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and write-back registers; the result strobe lasts one cycle by default-clearing valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      divisor_q     <= '0;
      op_q          <= DIV;
      rd_addr_q     <= '0;
      neg_quot_q    <= 1'b0;
      neg_rem_q     <= 1'b0;
      valid_q       <= 1'b0;
      rd_addr_out_q <= '0;
      rd_data_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (!flush_i) begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              op_q       <= div_op_e'(op_i);
              rd_addr_q  <= rd_addr_i;
              neg_quot_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              if (short_path) begin
                quot_q        <= short_quot;
                rem_q         <= short_rem;
                divisor_q     <= rs2_data_i;
                valid_q       <= 1'b1;
                rd_addr_out_q <= rd_addr_i;
                rd_data_q     <= op_i[1] ? short_rem : short_quot;
              end else begin
                quot_q    <= rs1_mag;
                rem_q     <= '0;
                divisor_q <= rs2_mag;
                cnt_q     <= CW'(XLEN - 1);
              end
            end
          end
          CALC: begin
            quot_q <= quot_nxt;
            rem_q  <= rem_nxt;
            if (cnt_q == '0) begin
              valid_q       <= 1'b1;
              rd_addr_out_q <= rd_addr_q;
              rd_data_q     <= is_rem_q ? rem_fix : quot_fix;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign valid_o   = valid_q;
  assign rd_addr_o = rd_addr_out_q;
  assign rd_data_o = rd_data_q;
  assign rd_wren_o = valid_q && (rd_addr_out_q != '0);

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_rv_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        valid_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wren_o;
  logic        busy_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  rv_div_unit #(.XLEN(32), .ADDRW(5)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .valid_o    (valid_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .rd_wren_o  (rd_wren_o),
    .busy_o     (busy_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output int lat);
    logic [31:0] q, r;
    bit sgn;
    sgn = !op[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      lat = 33;
    end else begin
      q = a / b; r = a % b; lat = 33;
    end
    res = op[1] ? r : q;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp;
    int lat, k;
    ref_model(op, a, b, exp, lat);
    k = 0;
    while (!ready_o && k < 100) begin @(posedge clk_i); #1; k++; end
    check_val({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    k = 0;
    while (!valid_o && k < 40) begin @(posedge clk_i); #1; k++; end
    check_val({tag, "_lat"},  32'(k + 1), 32'(lat));
    check_val({tag, "_data"}, rd_data_o, exp);
    check_val({tag, "_addr"}, {27'd0, rd_addr_o}, {27'd0, rd});
    check_val({tag, "_wren"}, {31'd0, rd_wren_o}, {31'd0, rd != 5'd0});
    check_val({tag, "_rdy_done"}, {31'd0, ready_o}, 32'd0);
    @(posedge clk_i); #1;
    check_val({tag, "_vdrop"}, {31'd0, valid_o}, 32'd0);
    check_val({tag, "_wdrop"}, {31'd0, rd_wren_o}, 32'd0);
    check_val({tag, "_rdy_after"}, {31'd0, ready_o}, 32'd1);
    check_val({tag, "_hold"}, rd_data_o, exp);
  endtask

  // Watches for stray result strobes over a number of cycles.
  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k, rdy_bad, n;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    op_i = 2'b00; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_ready", {31'd0, ready_o}, 32'd1);
    check_val("rst_busy",  {31'd0, busy_o},  32'd0);
    check_val("rst_valid", {31'd0, valid_o}, 32'd0);
    check_val("rst_wren",  {31'd0, rd_wren_o}, 32'd0);
    check_val("rst_addr",  {27'd0, rd_addr_o}, 32'd0);
    check_val("rst_data",  rd_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(2'b01, 32'd100, 32'd7, 5'd5, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 5'd5, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1, "rem_m7_2");
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd2, "div_7_m2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd2, "rem_7_m2");
    run_op(2'b01, 32'h1234_5678, 32'd0, 5'd3, "divu_by0");
    run_op(2'b10, 32'h1234_5678, 32'd0, 5'd3, "rem_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, "rem_ovf");
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, "divu_big");

    // valid_i held through the whole busy period must give exactly one accept
    @(negedge clk_i);
    op_i = 2'b01; rs1_data_i = 32'd9; rs2_data_i = 32'd3; rd_addr_i = 5'd0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    rdy_bad = 0; k = 0;
    while (!valid_o && k < 40) begin
      if (ready_o) rdy_bad++;
      @(posedge clk_i); #1; k++;
    end
    valid_i = 1'b0;
    check_val("hold_lat",  32'(k + 1), 32'd33);
    check_val("hold_data", rd_data_o, 32'd3);
    check_val("hold_wren", {31'd0, rd_wren_o}, 32'd0);
    check_val("hold_rdy_done", {31'd0, ready_o}, 32'd0);
    check_val("hold_rdy_busy", 32'(rdy_bad), 32'd0);
    count_strobes(40, n);
    check_val("hold_one_accept", 32'(n), 32'd0);

    // flush together with valid_i in IDLE: no accept
    @(negedge clk_i);
    op_i = 2'b01; rs1_data_i = 32'd8; rs2_data_i = 32'd2; rd_addr_i = 5'd6;
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check_val("flush_idle_busy", {31'd0, busy_o}, 32'd0);
    count_strobes(40, n);
    check_val("flush_idle_strobe", 32'(n), 32'd0);

    // flush during the 10th CALC cycle
    @(negedge clk_i);
    op_i = 2'b01; rs1_data_i = 32'hFFFF_FFFF; rs2_data_i = 32'd3; rd_addr_i = 5'd7; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n = 0;
    repeat (9) begin
      if (valid_o) n++;
      @(posedge clk_i); #1;
    end
    check_val("flush_calc_busy", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check_val("flush_valid", {31'd0, valid_o}, 32'd0);
    check_val("flush_wren",  {31'd0, rd_wren_o}, 32'd0);
    check_val("flush_ready", {31'd0, ready_o}, 32'd1);
    count_strobes(40, k);
    check_val("flush_no_strobe", 32'(n + k), 32'd0);
    run_op(2'b01, 32'd50, 32'd5, 5'd3, "post_flush");

    // asynchronous reset mid-CALC
    @(negedge clk_i);
    op_i = 2'b00; rs1_data_i = 32'd1000; rs2_data_i = 32'd9; rd_addr_i = 5'd9; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    #1 rst_ni = 1'b0;
    #1;
    check_val("arst_ready", {31'd0, ready_o}, 32'd1);
    check_val("arst_busy",  {31'd0, busy_o},  32'd0);
    check_val("arst_valid", {31'd0, valid_o}, 32'd0);
    check_val("arst_wren",  {31'd0, rd_wren_o}, 32'd0);
    check_val("arst_addr",  {27'd0, rd_addr_o}, 32'd0);
    check_val("arst_data",  rd_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    count_strobes(40, n);
    check_val("arst_no_strobe", 32'(n), 32'd0);
    run_op(2'b01, 32'd50, 32'd5, 5'd3, "post_reset");

    // randomized operations, biased towards the special cases
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 1000));
        default: a = $urandom;
      endcase
      rd = 5'($urandom_range(0, 31));
      run_op(op, a, b, rd, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
